// File: rtl/fifo_param.sv
// Parameterised synchronous FIFO with registered-read or first-word-fall-through
// output, programmable almost-full/almost-empty thresholds and sticky
// overflow/underflow flags.
module fifo_param #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  write,
  input  logic                  read,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH:0]   umb_almost_full,
  input  logic [ADDR_WIDTH:0]   umb_almost_empty,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  pop_ok;
  logic                  push_ok;

  // A push into a full FIFO is allowed when a pop frees the head slot in the same cycle.
  assign pop_ok  = read && (count != '0);
  assign push_ok = write && ((count != FULL_CNT) || pop_ok);

  // Status decodes come from the registered count only.
  assign data_count   = count;
  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == FULL_CNT);
  assign almost_full  = (count >= umb_almost_full);
  assign almost_empty = (count <= umb_almost_empty);

  // Storage array; contents are not reset, writes are held off while reset is asserted.
  always_ff @(posedge clk) begin
    if (reset_L && push_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins over clr_err.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write && !push_ok) overflow <= 1'b1;
      else if (clr_err)      overflow <= 1'b0;
      if (read && !pop_ok)   underflow <= 1'b1;
      else if (clr_err)      underflow <= 1'b0;
    end
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  vld_q;

      // Registered read: the popped word appears one cycle later with a one-cycle valid pulse.
      always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
          dout_q <= '0;
          vld_q  <= 1'b0;
        end else begin
          vld_q <= pop_ok;
          if (pop_ok) dout_q <= mem[rd_ptr];
        end
      end

      assign data_out = dout_q;
      assign valid    = vld_q;
    end else begin : g_fwft
      // Head word is presented directly; read acknowledges it. Zero when empty.
      assign valid    = (count != '0);
      assign data_out = valid ? mem[rd_ptr] : '0;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: a registered-read instance and a FWFT instance
// share one stimulus stream; each task checks its own scenario inline.
module tb_fifo_param;

  logic       clk;
  logic       reset_L;
  logic       write;
  logic       read;
  logic [5:0] data_in;
  logic [2:0] umb_almost_full;
  logic [2:0] umb_almost_empty;
  logic       clr_err;

  logic [5:0] r_data_out, f_data_out;
  logic       r_valid, f_valid;
  logic [2:0] r_count, f_count;
  logic       r_full, f_full, r_empty, f_empty;
  logic       r_af, f_af, r_ae, f_ae;
  logic       r_ovf, f_ovf, r_udf, f_udf;

  int checks   = 0;
  int failures = 0;

  fifo_param #(.DATA_WIDTH(6), .ADDR_WIDTH(2), .FWFT(0)) dut0 (
    .clk(clk), .reset_L(reset_L), .write(write), .read(read), .data_in(data_in),
    .umb_almost_full(umb_almost_full), .umb_almost_empty(umb_almost_empty),
    .clr_err(clr_err), .data_out(r_data_out), .valid(r_valid), .data_count(r_count),
    .fifo_full(r_full), .fifo_empty(r_empty), .almost_full(r_af), .almost_empty(r_ae),
    .overflow(r_ovf), .underflow(r_udf)
  );

  fifo_param #(.DATA_WIDTH(6), .ADDR_WIDTH(2), .FWFT(1)) dut1 (
    .clk(clk), .reset_L(reset_L), .write(write), .read(read), .data_in(data_in),
    .umb_almost_full(umb_almost_full), .umb_almost_empty(umb_almost_empty),
    .clr_err(clr_err), .data_out(f_data_out), .valid(f_valid), .data_count(f_count),
    .fifo_full(f_full), .fifo_empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .overflow(f_ovf), .underflow(f_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write = 1'b0; read = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    reset_L = 1'b0; idle(); data_in = 6'h00;
    umb_almost_full = 3'd3; umb_almost_empty = 3'd1;
    write = 1'b1; read = 1'b1; data_in = 6'h3F;
    cyc(); cyc();
    checks++; if (r_count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", r_count); end
    checks++; if ({r_empty, r_full, r_ae, r_af} !== 4'b1010) begin failures++; $display("FAIL rst_flags got=%b exp=1010", {r_empty, r_full, r_ae, r_af}); end
    checks++; if ({r_valid, f_valid, r_ovf, r_udf} !== 4'b0000) begin failures++; $display("FAIL rst_vld_err got=%b exp=0000", {r_valid, f_valid, r_ovf, r_udf}); end
    checks++; if ({r_data_out, f_data_out} !== 12'h000) begin failures++; $display("FAIL rst_dout got=%h exp=000", {r_data_out, f_data_out}); end
    umb_almost_full = 3'd0; #1;
    checks++; if (r_af !== 1'b1) begin failures++; $display("FAIL rst_af_zero got=%b exp=1", r_af); end
    umb_almost_full = 3'd3; idle(); #1;
    reset_L = 1'b1;
    cyc();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      write = 1'b1; data_in = 6'(i);
      cyc();
      checks++; if (r_count !== 3'(i)) begin failures++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, r_count, i); end
      checks++; if ({r_af, r_full} !== {(i >= 3), (i == 4)}) begin failures++; $display("FAIL fill_flags i=%0d got=%b exp=%b", i, {r_af, r_full}, {(i >= 3), (i == 4)}); end
      checks++; if ({f_valid, f_data_out} !== {1'b1, 6'h01}) begin failures++; $display("FAIL fill_fwft_head i=%0d got=%h exp=41", i, {f_valid, f_data_out}); end
    end
    data_in = 6'h3F;
    cyc();
    checks++; if ({r_count, r_ovf} !== {3'd4, 1'b1}) begin failures++; $display("FAIL overflow got cnt=%0d ovf=%b exp cnt=4 ovf=1", r_count, r_ovf); end
    clr_err = 1'b1;
    cyc();
    checks++; if (r_ovf !== 1'b1) begin failures++; $display("FAIL ovf_priority got=%b exp=1", r_ovf); end
    write = 1'b0;
    cyc();
    checks++; if (r_ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", r_ovf); end
    idle();
  endtask

  task automatic test_drain();
    read = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (f_data_out !== 6'(i)) begin failures++; $display("FAIL drain_fwft_head i=%0d got=%h exp=%h", i, f_data_out, 6'(i)); end
      cyc();
      checks++; if ({r_valid, r_data_out} !== {1'b1, 6'(i)}) begin failures++; $display("FAIL drain_dout i=%0d got=%h exp=%h", i, {r_valid, r_data_out}, {1'b1, 6'(i)}); end
      checks++; if ({r_count, r_ae, r_empty} !== {3'(4 - i), (i >= 3), (i == 4)}) begin failures++; $display("FAIL drain_status i=%0d got=%b exp=%b", i, {r_count, r_ae, r_empty}, {3'(4 - i), (i >= 3), (i == 4)}); end
    end
    cyc();
    checks++; if ({r_udf, r_valid, r_data_out} !== {1'b1, 1'b0, 6'h04}) begin failures++; $display("FAIL underflow got=%h exp=%h", {r_udf, r_valid, r_data_out}, {1'b1, 1'b0, 6'h04}); end
    checks++; if ({f_valid, f_data_out} !== 7'h00) begin failures++; $display("FAIL drain_fwft_empty got=%h exp=00", {f_valid, f_data_out}); end
    read = 1'b0; clr_err = 1'b1;
    cyc();
    checks++; if (r_udf !== 1'b0) begin failures++; $display("FAIL udf_clear got=%b exp=0", r_udf); end
    idle();
  endtask

  task automatic test_empty_rw();
    write = 1'b1; read = 1'b1; data_in = 6'h15;
    cyc();
    checks++; if ({r_count, r_udf, r_valid} !== {3'd1, 1'b1, 1'b0}) begin failures++; $display("FAIL empty_rw got=%b exp=00110", {r_count, r_udf, r_valid}); end
    checks++; if ({f_valid, f_data_out} !== {1'b1, 6'h15}) begin failures++; $display("FAIL empty_rw_fwft got=%h exp=55", {f_valid, f_data_out}); end
    write = 1'b0; clr_err = 1'b1;
    cyc();
    checks++; if ({r_count, r_valid, r_data_out, r_udf} !== {3'd0, 1'b1, 6'h15, 1'b0}) begin failures++; $display("FAIL empty_rw_pop got=%h exp=%h", {r_count, r_valid, r_data_out, r_udf}, {3'd0, 1'b1, 6'h15, 1'b0}); end
    idle();
  endtask

  task automatic test_full_rw();
    logic [5:0] exp_q [4];
    exp_q = '{6'h12, 6'h13, 6'h14, 6'h05};
    for (int i = 0; i < 4; i++) begin
      write = 1'b1; data_in = 6'h11 + 6'(i);
      cyc();
    end
    read = 1'b1; data_in = 6'h05;
    cyc();
    checks++; if ({r_count, r_ovf, r_data_out} !== {3'd4, 1'b0, 6'h11}) begin failures++; $display("FAIL full_rw got=%h exp=%h", {r_count, r_ovf, r_data_out}, {3'd4, 1'b0, 6'h11}); end
    write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if (r_data_out !== exp_q[i]) begin failures++; $display("FAIL full_rw_order i=%0d got=%h exp=%h", i, r_data_out, exp_q[i]); end
    end
    checks++; if (r_count !== 3'd0) begin failures++; $display("FAIL full_rw_count got=%0d exp=0", r_count); end
    idle();
  endtask

  task automatic test_wrap();
    write = 1'b1; data_in = 6'h20; cyc();
    data_in = 6'h21; cyc();
    read = 1'b1;
    for (int k = 0; k < 10; k++) begin
      data_in = 6'h22 + 6'(k);
      cyc();
      checks++; if ({r_count, r_data_out} !== {3'd2, 6'h20 + 6'(k)}) begin failures++; $display("FAIL wrap k=%0d got=%h exp=%h", k, {r_count, r_data_out}, {3'd2, 6'h20 + 6'(k)}); end
    end
    write = 1'b0;
    cyc();
    checks++; if (r_data_out !== 6'h2A) begin failures++; $display("FAIL wrap_tail0 got=%h exp=2a", r_data_out); end
    cyc();
    checks++; if ({r_count, r_data_out} !== {3'd0, 6'h2B}) begin failures++; $display("FAIL wrap_tail1 got=%h exp=%h", {r_count, r_data_out}, {3'd0, 6'h2B}); end
    idle();
  endtask

  task automatic test_fwft();
    write = 1'b1; data_in = 6'h2A;
    cyc();
    write = 1'b0;
    checks++; if ({f_valid, f_data_out} !== {1'b1, 6'h2A}) begin failures++; $display("FAIL fwft_show got=%h exp=6a", {f_valid, f_data_out}); end
    cyc();
    checks++; if ({f_valid, f_data_out, f_count} !== {1'b1, 6'h2A, 3'd1}) begin failures++; $display("FAIL fwft_hold got=%h exp=%h", {f_valid, f_data_out, f_count}, {1'b1, 6'h2A, 3'd1}); end
    read = 1'b1;
    cyc();
    read = 1'b0;
    checks++; if ({f_valid, f_data_out} !== 7'h00) begin failures++; $display("FAIL fwft_ack got=%h exp=00", {f_valid, f_data_out}); end
    checks++; if ({r_valid, r_data_out} !== {1'b1, 6'h2A}) begin failures++; $display("FAIL fwft_reg_pop got=%h exp=6a", {r_valid, r_data_out}); end
    idle();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin
      write = 1'b1; data_in = 6'h30 + 6'(i);
      cyc();
    end
    write = 1'b0; read = 1'b1;
    cyc();
    read = 1'b0;
    checks++; if ({r_count, r_ovf, r_valid} !== {3'd3, 1'b1, 1'b1}) begin failures++; $display("FAIL arst_setup got=%b exp=01111", {r_count, r_ovf, r_valid}); end
    #2 reset_L = 1'b0;
    #1;
    checks++; if ({r_count, r_ovf, r_udf, r_valid, f_valid} !== 7'b0000000) begin failures++; $display("FAIL arst_ctrl got=%b exp=0000000", {r_count, r_ovf, r_udf, r_valid, f_valid}); end
    checks++; if ({r_data_out, f_data_out, r_empty, r_ae} !== {12'h000, 2'b11}) begin failures++; $display("FAIL arst_out got=%h exp=%h", {r_data_out, f_data_out, r_empty, r_ae}, {12'h000, 2'b11}); end
    #2 reset_L = 1'b1;
    cyc();
    write = 1'b1; data_in = 6'h33;
    cyc();
    write = 1'b0;
    checks++; if ({dut0.wr_ptr, dut0.rd_ptr, r_count} !== {2'd1, 2'd0, 3'd1}) begin failures++; $display("FAIL arst_addr0 got=%b exp=0100001", {dut0.wr_ptr, dut0.rd_ptr, r_count}); end
    checks++; if (f_data_out !== 6'h33) begin failures++; $display("FAIL arst_fwft got=%h exp=33", f_data_out); end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_empty_rw();
    test_full_rw();
    test_wrap();
    test_fwft();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 6, meaning data bits per entry.
REQ-002 SHALL have parameter ADDR_WIDTH, default 2, meaning storage depth DEPTH = 2**ADDR_WIDTH entries.
REQ-003 SHALL have parameter FWFT, default 0, meaning 0 = registered-read mode and 1 = first-word-fall-through mode.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_L, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port write, input, 1 bit: push request.
REQ-007 SHALL have port read, input, 1 bit: pop request.
REQ-008 SHALL have port data_in, input, DATA_WIDTH bits: push data.
REQ-009 SHALL have port umb_almost_full, input, ADDR_WIDTH+1 bits: almost-full threshold.
REQ-010 SHALL have port umb_almost_empty, input, ADDR_WIDTH+1 bits: almost-empty threshold.
REQ-011 SHALL have port clr_err, input, 1 bit: clears sticky error flags.
REQ-012 SHALL have port data_out, output, DATA_WIDTH bits: pop data.
REQ-013 SHALL have port valid, output, 1 bit: data_out holds a popped or head word.
REQ-014 SHALL have port data_count, output, ADDR_WIDTH+1 bits: stored entries, 0..DEPTH.
REQ-015 SHALL have ports fifo_full, fifo_empty, almost_full and almost_empty, each output, 1 bit: status flags.
REQ-016 SHALL have ports overflow and underflow, each output, 1 bit: sticky error flags.

Function
REQ-017 Storage SHALL be a DEPTH x DATA_WIDTH register array indexed by ADDR_WIDTH-bit wr_ptr and rd_ptr that wrap DEPTH-1 -> 0; storage contents are not reset.
REQ-018 A pop SHALL be accepted (pop_ok) when read=1 and data_count!=0.
REQ-019 A push SHALL be accepted (push_ok) when write=1 and either data_count!=DEPTH or pop_ok=1 in the same cycle.
REQ-020 push_ok SHALL write data_in to mem[wr_ptr] and increment wr_ptr; pop_ok SHALL increment rd_ptr.
REQ-021 data_count SHALL update next cycle: +1 on push_ok only, -1 on pop_ok only, unchanged when both or neither occur.
REQ-022 Status flags SHALL decode combinationally from registered data_count: fifo_empty = (count==0); fifo_full = (count==DEPTH); almost_full = (count >= umb_almost_full); almost_empty = (count <= umb_almost_empty).
REQ-023 FWFT=0: on pop_ok, data_out SHALL load mem[rd_ptr] at the same edge and valid SHALL be 1 for exactly the following cycle; otherwise valid=0 and data_out holds its value.
REQ-024 FWFT=1: data_out SHALL equal mem[rd_ptr] while count!=0 and 0 while count==0; valid SHALL equal !fifo_empty; read acknowledges the displayed word.
REQ-025 Read and write on an empty FIFO SHALL accept only the push; the pop is rejected and underflow is set; the pushed word is visible next cycle in FWFT=1.
REQ-026 Read and write on a full FIFO SHALL accept both; count stays DEPTH and no overflow is flagged.
REQ-027 overflow SHALL set on the edge where write=1 and push_ok=0.
REQ-028 underflow SHALL set on the edge where read=1 and pop_ok=0.
REQ-029 overflow and underflow SHALL stay set until an edge with clr_err=1; clr_err clears them, but a same-cycle new error event takes priority and keeps the flag set.
REQ-030 A rejected push or pop SHALL not change pointers, count or storage.

Reset
REQ-031 reset_L=0 SHALL immediately clear wr_ptr, rd_ptr, data_count, data_out, valid, overflow and underflow, independent of clk.
REQ-032 While reset_L=0, flags SHALL read fifo_empty=1, fifo_full=0, almost_empty=1 and almost_full=(umb_almost_full==0); write and read are ignored.
REQ-033 Reset asserted mid-operation SHALL discard all stored entries; the first push after release lands at address 0.

Verification (DATA_WIDTH=6, ADDR_WIDTH=2, DEPTH=4, umb_almost_full=3, umb_almost_empty=1)
REQ-034 Push 0x01, 0x02, 0x03, 0x04, then one more write -> count goes 1, 2, 3, 4; almost_full at 3; fifo_full at 4; the fifth write sets overflow with count still 4.
REQ-035 FWFT=0, from full, read 4 cycles -> data_out shows 0x01..0x04 with valid pulses; count 4->0; almost_empty at 1; fifo_empty at 0; a fifth read sets underflow.
REQ-036 At full, read+write 0x05 in the same cycle -> count stays 4, no overflow, and 0x05 is later popped fourth.
REQ-037 Run 10 push/pop pairs at count 2 -> pointers wrap past 3 -> 0 and data order is preserved.
REQ-038 FWFT=1, push 0x2A into an empty FIFO -> the next cycle data_out=0x2A and valid=1 with no read; read -> valid=0 and data_out=0.
REQ-039 Assert reset_L=0 between clk edges with count=3 and overflow=1 -> all outputs reach reset values before the next edge; clr_err pulse test separately clears sticky flags.
